// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and instruction-fetch sequencer.
// Drives the instruction-memory req/ack handshake and latches the fetched word for decode.
module pc_fetch_ctrl #(
  parameter int unsigned W        = 32,
  parameter logic [W-1:0] RESET_PC = '0,
  parameter int unsigned INC      = 4,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] NextPC,
  input  logic         Stall,
  input  logic         ImemAck,
  input  logic [31:0]  ImemData,
  output logic [W-1:0] PC,
  output logic [W-1:0] PCPlus4,
  output logic         ImemReq,
  output logic [W-1:0] ImemAddr,
  output logic [31:0]  Instr,
  output logic         InstrValid,
  output logic         Fault
);

  localparam int unsigned IW = 32;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  pc_q, pc_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          valid_q, valid_d;
  logic          fault_q, fault_d;

  // Next-state and registered-output decode; outputs follow the state being entered.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    valid_d = valid_q;
    fault_d = fault_q;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
        req_d   = 1'b1;
        cnt_d   = '0;
      end
      FETCH: begin
        if (ImemAck) begin
          instr_d = ImemData;
          cnt_d   = '0;
          state_d = EXEC;
          req_d   = 1'b0;
          valid_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = FAULT;
          req_d   = 1'b0;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      EXEC: begin
        if (!Stall) begin
          valid_d = 1'b0;
          if (NextPC[1:0] == 2'b00) begin
            pc_d    = NextPC;
            state_d = FETCH;
            req_d   = 1'b1;
          end else begin
            state_d = FAULT;
            fault_d = 1'b1;
          end
        end
      end
      FAULT: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
      default: state_d = FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  // Incrementer wraps modulo 2^W by design.
  assign PCPlus4    = pc_q + W'(INC);
  assign PC         = pc_q;
  assign ImemAddr   = pc_q;
  assign ImemReq    = req_q;
  assign Instr      = instr_q;
  assign InstrValid = valid_q;
  assign Fault      = fault_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus a randomized instruction stream
// checked against a transaction-level PC/instruction model.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] NextPC;
  logic        Stall;
  logic        ImemAck;
  logic [31:0] ImemData;
  logic [31:0] PC, PCPlus4, ImemAddr, Instr;
  logic        ImemReq, InstrValid, Fault;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] pc_exp;
  logic [31:0] instr_exp;

  pc_fetch_ctrl #(.W(32), .RESET_PC(32'h0), .INC(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .NextPC(NextPC), .Stall(Stall),
    .ImemAck(ImemAck), .ImemData(ImemData), .PC(PC), .PCPlus4(PCPlus4),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .Instr(Instr),
    .InstrValid(InstrValid), .Fault(Fault)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; ImemAck = 1'b0; Stall = 1'b0;
    tick();
    reset = 1'b0;
    pc_exp = 32'h0; instr_exp = 32'h0;
    tick();  // BOOT -> FETCH
  endtask

  task automatic test_reset();
    reset = 1'b1; NextPC = 32'h0; Stall = 1'b0; ImemAck = 1'b0; ImemData = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (PC !== 32'h0 || InstrValid !== 1'b0 || ImemReq !== 1'b0 || Fault !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: PC=%h IV=%b Req=%b Fault=%b, want 0/0/0/0", i, PC, InstrValid, ImemReq, Fault);
      end
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (ImemReq !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_boot: ImemReq=%b want 0", ImemReq);
    end
    tick();
    n_checks++;
    if (ImemReq !== 1'b1 || ImemAddr !== 32'h0 || InstrValid !== 1'b0) begin
      n_fail++; $display("FAIL reset_first_fetch: Req=%b Addr=%h IV=%b want 1/0/0", ImemReq, ImemAddr, InstrValid);
    end
    pc_exp = 32'h0;
  endtask

  task automatic test_normal_fetch();
    ImemAck = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (ImemReq !== 1'b1 || InstrValid !== 1'b0 || ImemAddr !== 32'h0) begin
        n_fail++; $display("FAIL fetch_wait%0d: Req=%b IV=%b Addr=%h want 1/0/0", i, ImemReq, InstrValid, ImemAddr);
      end
    end
    n_checks++;
    if (PCPlus4 !== 32'h4) begin
      n_fail++; $display("FAIL pcplus4_zero: PCPlus4=%h want 4", PCPlus4);
    end
    ImemAck = 1'b1; ImemData = 32'h2002_0005; NextPC = 32'h4; Stall = 1'b0;
    tick();
    ImemAck = 1'b0;
    n_checks++;
    if (Instr !== 32'h2002_0005 || InstrValid !== 1'b1 || ImemReq !== 1'b0 || PC !== 32'h0) begin
      n_fail++; $display("FAIL fetch_latch: Instr=%h IV=%b Req=%b PC=%h want 20020005/1/0/0", Instr, InstrValid, ImemReq, PC);
    end
    tick();
    n_checks++;
    if (PC !== 32'h4 || ImemReq !== 1'b1 || ImemAddr !== 32'h4 || InstrValid !== 1'b0 || PCPlus4 !== 32'h8) begin
      n_fail++; $display("FAIL fetch_advance: PC=%h Req=%b Addr=%h IV=%b P4=%h want 4/1/4/0/8", PC, ImemReq, ImemAddr, InstrValid, PCPlus4);
    end
    pc_exp = 32'h4;
  endtask

  task automatic test_stall();
    logic [31:0] data;
    data = $urandom();
    ImemAck = 1'b1; ImemData = data; Stall = 1'b1; NextPC = 32'h40;
    tick();
    ImemAck = 1'b0;
    for (int i = 0; i < 4; i++) begin
      // An ack outside FETCH must not disturb the latched instruction.
      ImemAck  = (i == 1);
      ImemData = ~data;
      tick();
      n_checks++;
      if (PC !== pc_exp || Instr !== data || InstrValid !== 1'b1 || ImemReq !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold%0d: PC=%h Instr=%h IV=%b Req=%b want %h/%h/1/0", i, PC, Instr, InstrValid, ImemReq, pc_exp, data);
      end
    end
    ImemAck = 1'b0; Stall = 1'b0;
    tick();
    n_checks++;
    if (PC !== 32'h40 || ImemReq !== 1'b1 || ImemAddr !== 32'h40) begin
      n_fail++; $display("FAIL stall_release: PC=%h Req=%b Addr=%h want 40/1/40", PC, ImemReq, ImemAddr);
    end
    pc_exp = 32'h40;
  endtask

  task automatic test_misaligned();
    ImemAck = 1'b1; ImemData = 32'h1234_5678; Stall = 1'b0; NextPC = 32'h42;
    tick();
    ImemAck = 1'b0;
    tick();
    n_checks++;
    if (Fault !== 1'b1 || PC !== 32'h40 || ImemReq !== 1'b0 || InstrValid !== 1'b0) begin
      n_fail++; $display("FAIL misalign: Fault=%b PC=%h Req=%b IV=%b want 1/40/0/0", Fault, PC, ImemReq, InstrValid);
    end
    NextPC = 32'h80;
    for (int i = 0; i < 3; i++) begin
      ImemAck = 1'b1;
      tick();
      n_checks++;
      if (Fault !== 1'b1 || ImemReq !== 1'b0 || PC !== 32'h40) begin
        n_fail++; $display("FAIL fault_sticky%0d: Fault=%b Req=%b PC=%h want 1/0/40", i, Fault, ImemReq, PC);
      end
    end
    apply_reset();
  endtask

  task automatic test_timeout();
    ImemAck = 1'b0;
    // Currently in the first FETCH cycle; fault must appear only after the 15th.
    for (int i = 1; i <= 15; i++) begin
      tick();
      n_checks++;
      if (Fault !== (i == 15)) begin
        n_fail++; $display("FAIL timeout_cyc%0d: Fault=%b want %b", i, Fault, (i == 15));
      end
    end
    n_checks++;
    if (ImemReq !== 1'b0) begin
      n_fail++; $display("FAIL timeout_req: ImemReq=%b want 0", ImemReq);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (Fault !== 1'b0 || PC !== 32'h0 || ImemReq !== 1'b0) begin
      n_fail++; $display("FAIL timeout_reset: Fault=%b PC=%h Req=%b want 0/0/0", Fault, PC, ImemReq);
    end
    reset = 1'b0;
    tick();
    pc_exp = 32'h0;
  endtask

  task automatic test_reset_mid_fetch();
    ImemAck = 1'b1; ImemData = 32'hDEAD_BEEF; reset = 1'b1;
    tick();
    n_checks++;
    if (Instr !== 32'h0 || InstrValid !== 1'b0 || ImemReq !== 1'b0 || PC !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_fetch: Instr=%h IV=%b Req=%b PC=%h want 0/0/0/0", Instr, InstrValid, ImemReq, PC);
    end
    ImemAck = 1'b0; reset = 1'b0;
    tick();
    pc_exp = 32'h0;
  endtask

  task automatic test_wrap();
    logic [31:0] wrapped;
    ImemAck = 1'b1; ImemData = 32'h0; Stall = 1'b0; NextPC = 32'hFFFF_FFFC;
    tick();
    ImemAck = 1'b0;
    tick();
    wrapped = 32'hFFFF_FFFC + 32'd4;
    n_checks++;
    if (PC !== 32'hFFFF_FFFC || PCPlus4 !== wrapped) begin
      n_fail++; $display("FAIL wrap_pcplus4: PC=%h P4=%h want fffffffc/%h", PC, PCPlus4, wrapped);
    end
    ImemAck = 1'b1; NextPC = wrapped;
    tick();
    ImemAck = 1'b0;
    tick();
    n_checks++;
    if (ImemAddr !== 32'h0 || ImemReq !== 1'b1 || Fault !== 1'b0) begin
      n_fail++; $display("FAIL wrap_fetch: Addr=%h Req=%b Fault=%b want 0/1/0", ImemAddr, ImemReq, Fault);
    end
    pc_exp = 32'h0;
  endtask

  // Transaction model: every instruction = random ack delay, fetch, random stalls, aligned jump.
  task automatic test_random();
    int unsigned delay, stalls;
    logic [31:0] data, target;
    for (int n = 0; n < 40; n++) begin
      delay  = $urandom_range(0, 5);
      stalls = $urandom_range(0, 3);
      data   = $urandom();
      target = $urandom();
      target = target & 32'hFFFF_FFFC;
      Stall = 1'b0;
      for (int unsigned d = 0; d < delay; d++) begin
        ImemAck = 1'b0;
        Stall   = $urandom_range(0, 1);
        tick();
        n_checks++;
        if (ImemReq !== 1'b1 || ImemAddr !== pc_exp || InstrValid !== 1'b0) begin
          n_fail++; $display("FAIL rnd%0d_wait: Req=%b Addr=%h IV=%b want 1/%h/0", n, ImemReq, ImemAddr, InstrValid, pc_exp);
        end
      end
      ImemAck = 1'b1; ImemData = data; Stall = 1'b1;
      tick();
      instr_exp = data;
      for (int unsigned s = 0; s < stalls; s++) begin
        ImemAck = $urandom_range(0, 1); ImemData = $urandom(); NextPC = $urandom();
        tick();
        n_checks++;
        if (PC !== pc_exp || Instr !== instr_exp || InstrValid !== 1'b1) begin
          n_fail++; $display("FAIL rnd%0d_stall: PC=%h Instr=%h IV=%b want %h/%h/1", n, PC, Instr, InstrValid, pc_exp, instr_exp);
        end
      end
      n_checks++;
      if (Instr !== instr_exp || InstrValid !== 1'b1 || ImemReq !== 1'b0) begin
        n_fail++; $display("FAIL rnd%0d_exec: Instr=%h IV=%b Req=%b want %h/1/0", n, Instr, InstrValid, ImemReq, instr_exp);
      end
      ImemAck = 1'b0; Stall = 1'b0; NextPC = target;
      tick();
      pc_exp = target;
      n_checks++;
      if (PC !== pc_exp || ImemReq !== 1'b1 || PCPlus4 !== (pc_exp + 32'd4) || Fault !== 1'b0) begin
        n_fail++; $display("FAIL rnd%0d_jump: PC=%h Req=%b P4=%h Fault=%b want %h/1/%h/0", n, PC, ImemReq, PCPlus4, Fault, pc_exp, pc_exp + 32'd4);
      end
    end
  endtask

  initial begin
    pc_exp = 32'h0; instr_exp = 32'h0;
    test_reset();
    test_normal_fetch();
    test_stall();
    test_misaligned();
    test_timeout();
    test_reset_mid_fetch();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
